bus_arbiter: RTL

- Shares one external memory bus between the instruction-fetch master (IF stage) and the data master (MEM stage).
- Sits between the CPU core buses and the SRAM/peripheral controller.
- Arbitrates fixed-priority, data first, with an anti-starvation counter for instruction fetch.
- Allows one outstanding transaction at a time and registers all bus-side and master-side outputs.

---
 rtl/bus_arbiter.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/bus_arbiter.sv
// Two-master (instruction fetch / data) arbiter onto one single-outstanding memory bus.
// Optional bus timeout is compiled in with `define BUS_ARB_TIMEOUT_EN.
module bus_arbiter #(
  parameter int unsigned INST_STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT_CYCLES    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic [31:0] inst_rdata,
  output logic        inst_done,
  output logic        inst_err,
  input  logic        data_req,
  input  logic        data_we,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_done,
  output logic        data_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready
);

  localparam int unsigned SW = $clog2(INST_STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(INST_STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY_DATA = 2'd1,
    BUSY_INST = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          bus_req_q, bus_req_d;
  logic          bus_we_q, bus_we_d;
  logic [3:0]    bus_be_q, bus_be_d;
  logic [31:0]   bus_addr_q, bus_addr_d;
  logic [31:0]   bus_wdata_q, bus_wdata_d;
  logic          inst_done_q, inst_done_d;
  logic          inst_err_q, inst_err_d;
  logic [31:0]   inst_rdata_q, inst_rdata_d;
  logic          data_done_q, data_done_d;
  logic          data_err_q, data_err_d;
  logic [31:0]   data_rdata_q, data_rdata_d;

  logic          under_limit, data_pri, grant_data, grant_inst, inst_pend;
  logic          tmo_hit, fin, fin_err;
  logic [31:0]   fin_rdata;

  // A master completing this cycle keeps its priority claim but cannot be
  // granted; the other master only wins if it would have won anyway.
  assign under_limit = (starve_q < STARVE_MAX);
  assign data_pri    = data_req & (~inst_req | under_limit);
  assign grant_data  = data_pri & ~data_done_q;
  assign grant_inst  = ~data_pri & inst_req & ~inst_done_q;
  assign inst_pend   = inst_req & ~inst_done_q;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);
  logic [TW-1:0] tmo_q, tmo_d;

  assign tmo_hit = (tmo_q == TMO_MAX);

  // Busy-cycle counter; held at zero in IDLE so every grant starts fresh.
  always_comb begin
    tmo_d = tmo_q;
    if (state_q == IDLE) begin
      tmo_d = {TW{1'b0}};
    end else if (tmo_hit) begin
      tmo_d = tmo_q;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= {TW{1'b0}};
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  localparam int unsigned tmo_unused = TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  // bus_ready wins over a coincident timeout.
  assign fin       = bus_ready | tmo_hit;
  assign fin_err   = tmo_hit & ~bus_ready;
  assign fin_rdata = (bus_ready & ~bus_we_q) ? bus_rdata : 32'h0000_0000;

  always_comb begin
    state_d      = state_q;
    starve_d     = starve_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_be_d     = bus_be_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    inst_done_d  = 1'b0;
    inst_err_d   = 1'b0;
    inst_rdata_d = inst_rdata_q;
    data_done_d  = 1'b0;
    data_err_d   = 1'b0;
    data_rdata_d = data_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_data) begin
          state_d     = BUSY_DATA;
          bus_req_d   = 1'b1;
          bus_we_d    = data_we;
          bus_be_d    = data_be;
          bus_addr_d  = data_addr;
          bus_wdata_d = data_wdata;
          if (~inst_pend) begin
            starve_d = {SW{1'b0}};
          end else if (under_limit) begin
            starve_d = starve_q + 1'b1;
          end else begin
            starve_d = starve_q;
          end
        end else if (grant_inst) begin
          state_d     = BUSY_INST;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_be_d    = 4'hF;
          bus_addr_d  = inst_addr;
          bus_wdata_d = 32'h0000_0000;
          starve_d    = {SW{1'b0}};
        end else if (~inst_pend) begin
          starve_d = {SW{1'b0}};
        end else begin
          starve_d = starve_q;
        end
      end
      BUSY_DATA: begin
        if (fin) begin
          state_d      = IDLE;
          bus_req_d    = 1'b0;
          data_done_d  = 1'b1;
          data_err_d   = fin_err;
          data_rdata_d = fin_rdata;
        end else begin
          state_d = BUSY_DATA;
        end
      end
      BUSY_INST: begin
        if (fin) begin
          state_d      = IDLE;
          bus_req_d    = 1'b0;
          inst_done_d  = 1'b1;
          inst_err_d   = fin_err;
          inst_rdata_d = fin_rdata;
        end else begin
          state_d = BUSY_INST;
        end
      end
      default: begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      starve_q     <= {SW{1'b0}};
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_be_q     <= 4'h0;
      bus_addr_q   <= 32'h0000_0000;
      bus_wdata_q  <= 32'h0000_0000;
      inst_done_q  <= 1'b0;
      inst_err_q   <= 1'b0;
      inst_rdata_q <= 32'h0000_0000;
      data_done_q  <= 1'b0;
      data_err_q   <= 1'b0;
      data_rdata_q <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_be_q     <= bus_be_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      inst_done_q  <= inst_done_d;
      inst_err_q   <= inst_err_d;
      inst_rdata_q <= inst_rdata_d;
      data_done_q  <= data_done_d;
      data_err_q   <= data_err_d;
      data_rdata_q <= data_rdata_d;
    end
  end

  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_be     = bus_be_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign inst_done  = inst_done_q;
  assign inst_err   = inst_err_q;
  assign inst_rdata = inst_rdata_q;
  assign data_done  = data_done_q;
  assign data_err   = data_err_q;
  assign data_rdata = data_rdata_q;

endmodule
